// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the multi-cycle shifter: widths, opcode encodings and FSM states.
// Instruction decode imports the opcode encodings from here as well.
package shift_sequencer_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute stage and the shift sequencer.
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic                ctrl_shift;
  logic [WIDTH-1:0]    data_operand;
  logic [SHW-1:0]      ctrl_shamt;
  logic [1:0]          ctrl_op;
  logic [WIDTH-1:0]    data_result;
  logic                data_resultRDY;
  logic                ready;

  modport master (
    output ctrl_shift, data_operand, ctrl_shamt, ctrl_op,
    input  data_result, data_resultRDY, ready
  );

  modport slave (
    input  ctrl_shift, data_operand, ctrl_shamt, ctrl_op,
    output data_result, data_resultRDY, ready
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Fixed 2-bit shift stages reused every cycle by the sequencer.
// sll_2 is the left stage; shift_right_2 covers both SRL and SRA.
module sll_2
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  assign out = {in[WIDTH-3:0], 2'b00};
endmodule

module shift_right_2
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  input  logic             arith,
  output logic [WIDTH-1:0] out
);
  logic [1:0] fill_s;

  assign fill_s = arith ? {2{in[WIDTH-1]}} : 2'b00;
  assign out    = {fill_s, in[WIDTH-1:2]};
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: applies the shift amount 2 bits per cycle (1 bit for an odd tail).
// ready drops while shifting; data_resultRDY pulses for one cycle with the registered result.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  acc_r, acc_s;
  logic [SHW-1:0]    rem_r, rem_s;
  logic [1:0]        op_r, op_s;
  logic [WIDTH-1:0]  result_r, result_s;
  logic              result_load_s;
  logic              rdy_r, ready_r;

  logic [WIDTH-1:0]  sll2_s, sr2_s, sll1_s, sr1_s, step_acc_s;
  logic [SHW-1:0]    step_rem_s;
  logic              arith_s;

  assign arith_s = (op_r == SH_SRA);

  sll_2 u_sll_2 (
    .in  (acc_r),
    .out (sll2_s)
  );

  shift_right_2 u_shift_right_2 (
    .in    (acc_r),
    .arith (arith_s),
    .out   (sr2_s)
  );

  assign sll1_s = {acc_r[WIDTH-2:0], 1'b0};
  assign sr1_s  = {(arith_s ? acc_r[WIDTH-1] : 1'b0), acc_r[WIDTH-1:1]};

  // Step select: reserved opcode 11 falls into the default branch, i.e. behaves as SLL
  always_comb begin
    step_acc_s = acc_r;
    case (op_r)
      SH_SRA, SH_SRL: step_acc_s = (rem_r >= 5'd2) ? sr2_s : sr1_s;
      default:        step_acc_s = (rem_r >= 5'd2) ? sll2_s : sll1_s;
    endcase
    if (rem_r >= 5'd2) begin
      step_rem_s = rem_r - 5'd2;
    end else begin
      step_rem_s = 5'd0;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath-load decode
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    rem_s         = rem_r;
    op_s          = op_r;
    result_s      = result_r;
    result_load_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.ctrl_shift) begin
          acc_s = bus.data_operand;
          rem_s = bus.ctrl_shamt;
          op_s  = bus.ctrl_op;
          if (bus.ctrl_shamt == 5'd0) begin
            state_s       = ST_DONE;
            result_s      = bus.data_operand;
            result_load_s = 1'b1;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_s = step_acc_s;
        rem_s = step_rem_s;
        // Final step lands on the same edge that enters DONE, so the result is loaded here
        if (rem_r <= 5'd2) begin
          state_s       = ST_DONE;
          result_s      = step_acc_s;
          result_load_s = 1'b1;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r    <= 32'h0000_0000;
      rem_r    <= 5'd0;
      op_r     <= 2'b00;
      result_r <= 32'h0000_0000;
      rdy_r    <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      acc_r    <= acc_s;
      rem_r    <= rem_s;
      op_r     <= op_s;
      rdy_r    <= result_load_s;
      ready_r  <= (state_s != ST_SHIFT);
      if (result_load_s) begin
        result_r <= result_s;
      end
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_resultRDY = rdy_r;
  assign bus.ready          = ready_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, shift semantics, back-to-back, ignore-while-busy, reset.
module tb_shift_sequencer;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue at a negedge; returns right after the accepting posedge with inputs scrambled
  task automatic issue(input logic [1:0] op, input logic [31:0] val, input logic [4:0] sh);
    bus.ctrl_op      = op;
    bus.data_operand = val;
    bus.ctrl_shamt   = sh;
    bus.ctrl_shift   = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_shift   = 1'b0;
    bus.data_operand = 32'hA5A5_5A5A;
    bus.ctrl_shamt   = 5'd7;
    bus.ctrl_op      = 2'b01;
  endtask

  // Waits for RDY (bounded); checks latency, result and ready low while busy
  task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat);
    int  lat;
    bit  seen;
    bit  busy_ok;
    lat     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        seen = 1'b1;
        lat  = i;
      end else if (bus.ready !== 1'b0) begin
        busy_ok = 1'b0;
      end
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.data_result, exp);
    chk({tag, "_ready_done"}, {31'd0, bus.ready}, 32'd1);
    if (exp_lat > 1) begin
      chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    end
  endtask

  task automatic run_job(input string tag, input logic [1:0] op, input logic [31:0] val,
                         input logic [4:0] sh, input logic [31:0] exp, input int exp_lat);
    issue(op, val, sh);
    wait_done(tag, exp, exp_lat);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    reset            = 1'b1;
    bus.ctrl_shift   = 1'b0;
    bus.data_operand = 32'h0000_0000;
    bus.ctrl_shamt   = 5'd0;
    bus.ctrl_op      = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_result", bus.data_result, 32'h0000_0000);
    chk("rst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    reset = 1'b0;
    @(negedge clock);

    // 1-3: basic semantics and latency A+1+ceil(shamt/2)
    run_job("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 17);
    run_job("sra3",  2'b01, 32'h8000_0000, 5'd3,  32'hF000_0000, 3);
    run_job("srl3",  2'b10, 32'h8000_0000, 5'd3,  32'h1000_0000, 3);
    run_job("sh0",   2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
    run_job("sh0r",  2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
    run_job("sra31", 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 17);
    run_job("srl31", 2'b10, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 17);
    run_job("sra5p", 2'b01, 32'h7000_0000, 5'd5,  32'h0380_0000, 4);
    run_job("sll2",  2'b00, 32'h1234_5678, 5'd2,  32'h48D1_59E0, 2);

    // 4: back-to-back, second job accepted in the DONE cycle of the first
    issue(2'b00, 32'h0000_0001, 5'd2);
    @(negedge clock);
    chk("b2b_a1_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    @(negedge clock);
    chk("b2b_a2_rdy", {31'd0, bus.data_resultRDY}, 32'd1);
    chk("b2b_a2_res", bus.data_result, 32'h0000_0004);
    chk("b2b_a2_ready", {31'd0, bus.ready}, 32'd1);
    issue(2'b01, 32'hFFFF_FF00, 5'd4);
    wait_done("b2b2", 32'hFFFF_FFF0, 3);

    // 5: request during SHIFT is dropped, not queued
    issue(2'b00, 32'h0000_0001, 5'd6);
    @(negedge clock);
    bus.ctrl_op      = 2'b10;
    bus.data_operand = 32'h0000_FFFF;
    bus.ctrl_shamt   = 5'd0;
    bus.ctrl_shift   = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_shift = 1'b0;
    wait_done("ign", 32'h0000_0040, 3);
    @(negedge clock);
    chk("ign_noq_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    chk("ign_noq_res", bus.data_result, 32'h0000_0040);
    run_job("op11", 2'b11, 32'h0000_0003, 5'd1, 32'h0000_0006, 2);

    // 6: reset mid-shift abandons the job
    issue(2'b00, 32'h0000_0001, 5'd20);
    repeat (3) @(negedge clock);
    chk("mid_ready_busy", {31'd0, bus.ready}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_res", bus.data_result, 32'h0000_0000);
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    begin
      bit pulse;
      pulse = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clock);
        if (bus.data_resultRDY) pulse = 1'b1;
      end
      chk("mid_rst_nopulse", {31'd0, pulse}, 32'd0);
    end
    run_job("fresh", 2'b10, 32'h0000_00F0, 5'd4, 32'h0000_000F, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
